// File: rtl/sp_phy_pkg.sv
// Purpose : shared constants for the phy rx serial-to-parallel deserialiser.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
//
// Contents: FSM state encoding, default comma and lock/loss thresholds, and a
// helper that sizes a counter able to hold 0..max_val.
package sp_phy_pkg;

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_ALIGN  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [7:0] DEF_COMMA      = 8'hBC;
    localparam int         DEF_LOCK_COUNT = 4;
    localparam int         DEF_LOSS_COUNT = 2;

    // Bits needed to count from 0 up to and including max_val (at least 1).
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sp_comma_detect.sv
// Purpose : serial-in shift register with comma comparator for the rx deserialiser.
// Latency : o_shift_q updates on the edge that samples i_data; o_match is combinational on o_shift_q.
// Backpr. : none -- exactly one bit is accepted every clk_32f cycle.
//
// Ports:
//   clk_32f   in   bit clock, rising edge
//   reset_L   in   asynchronous active-low reset
//   i_data    in   serial bit, MSB of each symbol first
//   o_shift_q out  last WIDTH received bits, newest in bit 0
//   o_match   out  o_shift_q equals COMMA
module sp_comma_detect
    import sp_phy_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] COMMA = WIDTH'(DEF_COMMA)
) (
    input  logic             clk_32f,
    input  logic             reset_L,
    input  logic             i_data,
    output logic [WIDTH-1:0] o_shift_q,
    output logic             o_match
);

    logic [WIDTH-1:0] r_shift_q;

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            r_shift_q <= '0;
        end else begin
            r_shift_q <= {r_shift_q[WIDTH-2:0], i_data};
        end
    end

    assign o_shift_q = r_shift_q;
    assign o_match   = (r_shift_q == COMMA);

endmodule

// File: rtl/serial_paralelo_phy_rx_param.sv
// Purpose : phy rx deserialiser -- comma alignment, N-comma lock acquisition, loss-of-sync detection.
// Latency : last bit of a symbol enters the shifter at edge t; data_out/data_valid update at edge t+1.
// Backpr. : none -- free-running bit stream; data_valid is a one-cycle strobe with no ready.
//
// Optional feature macro: SP_ERR_CNT_EN adds parameter ERR_W and output err_count,
// a saturating count of off-boundary commas seen in ALIGN or LOCKED.
//
// Ports:
//   clk_32f    in   bit clock, rising edge
//   reset_L    in   asynchronous active-low reset
//   data_in    in   serial bit stream, MSB first
//   data_out   out  last captured aligned symbol
//   data_valid out  one-cycle pulse when data_out updates
//   comma_det  out  captured symbol equals COMMA
//   active     out  high while LOCKED
//   idle_out   out  active and captured symbol is not COMMA
//   sync_lost  out  one-cycle pulse on LOCKED -> HUNT
//   err_count  out  (SP_ERR_CNT_EN only) off-boundary comma count
module serial_paralelo_phy_rx_param
    import sp_phy_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DEF_COMMA),
    parameter int               LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int               LOSS_COUNT = DEF_LOSS_COUNT
`ifdef SP_ERR_CNT_EN
   ,parameter int               ERR_W      = 8
`endif
) (
    input  logic             clk_32f,
    input  logic             reset_L,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             comma_det,
    output logic             active,
    output logic             idle_out,
    output logic             sync_lost
`ifdef SP_ERR_CNT_EN
   ,output logic [ERR_W-1:0] err_count
`endif
);

    localparam int               BIT_W    = $clog2(WIDTH);
    localparam int               CC_W     = cnt_w(LOCK_COUNT);
    localparam int               BC_W     = cnt_w(LOSS_COUNT);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    logic [WIDTH-1:0] w_shift_q;
    logic             w_match;
    logic             w_boundary;

    logic [1:0]       r_state;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [CC_W-1:0]  r_comma_cnt;
    logic [BC_W-1:0]  r_bad_cnt;
    logic             r_active;
    logic             r_sync_lost;
    logic             r_data_valid;
    logic [WIDTH-1:0] r_data_out;
    logic             r_comma_det;
    logic             r_idle;

    logic [1:0]       w_state_nxt;
    logic [BIT_W-1:0] w_bit_cnt_nxt;
    logic [CC_W-1:0]  w_comma_cnt_nxt;
    logic [BC_W-1:0]  w_bad_cnt_nxt;
    logic             w_active_nxt;
    logic             w_capture;
    logic             w_sync_lost;

    sp_comma_detect #(
        .WIDTH (WIDTH),
        .COMMA (COMMA)
    ) u_comma_detect (
        .clk_32f   (clk_32f),
        .reset_L   (reset_L),
        .i_data    (data_in),
        .o_shift_q (w_shift_q),
        .o_match   (w_match)
    );

    assign w_boundary = (r_bit_cnt == LAST_BIT);

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_comma_cnt_nxt = r_comma_cnt;
        w_bad_cnt_nxt   = r_bad_cnt;
        w_active_nxt    = r_active;
        w_capture       = 1'b0;
        w_sync_lost     = 1'b0;

        case (r_state)
            ST_HUNT: begin
                // Bit counter is frozen here; the first comma anchors the grid.
                if (w_match) begin
                    w_capture       = 1'b1;
                    w_bit_cnt_nxt   = '0;
                    w_comma_cnt_nxt = CC_W'(1);
                    if (LOCK_COUNT == 1) begin
                        w_state_nxt  = ST_LOCKED;
                        w_active_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = ST_ALIGN;
                    end
                end
            end

            ST_ALIGN: begin
                w_bit_cnt_nxt = w_boundary ? '0 : r_bit_cnt + 1'b1;
                if (w_boundary) begin
                    w_capture = 1'b1;
                    if (w_match) begin
                        w_comma_cnt_nxt = r_comma_cnt + 1'b1;
                        if (int'(r_comma_cnt) + 1 >= LOCK_COUNT) begin
                            w_state_nxt  = ST_LOCKED;
                            w_active_nxt = 1'b1;
                        end
                    end
                end else if (w_match) begin
                    // Comma off the current grid: re-anchor on it and restart acquisition.
                    w_capture       = 1'b1;
                    w_bit_cnt_nxt   = '0;
                    w_comma_cnt_nxt = CC_W'(1);
                end
            end

            ST_LOCKED: begin
                w_bit_cnt_nxt = w_boundary ? '0 : r_bit_cnt + 1'b1;
                if (w_boundary) begin
                    w_capture = 1'b1;
                    if (w_match) begin
                        w_bad_cnt_nxt = '0;
                    end
                end else if (w_match) begin
                    // Misaligned comma is not captured; enough of them drop the lock.
                    // HUNT re-detects on a later match, never on this edge.
                    if (int'(r_bad_cnt) + 1 >= LOSS_COUNT) begin
                        w_state_nxt     = ST_HUNT;
                        w_active_nxt    = 1'b0;
                        w_sync_lost     = 1'b1;
                        w_comma_cnt_nxt = '0;
                        w_bad_cnt_nxt   = '0;
                    end else begin
                        w_bad_cnt_nxt   = r_bad_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt  = ST_HUNT;
                w_active_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            r_state      <= ST_HUNT;
            r_bit_cnt    <= '0;
            r_comma_cnt  <= '0;
            r_bad_cnt    <= '0;
            r_active     <= 1'b0;
            r_sync_lost  <= 1'b0;
            r_data_valid <= 1'b0;
            r_data_out   <= '0;
            r_comma_det  <= 1'b0;
            r_idle       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_comma_cnt  <= w_comma_cnt_nxt;
            r_bad_cnt    <= w_bad_cnt_nxt;
            r_active     <= w_active_nxt;
            r_sync_lost  <= w_sync_lost;
            r_data_valid <= w_capture;
            // comma_det/idle_out only move on capture edges; idle uses the
            // active value being written on this same edge.
            if (w_capture) begin
                r_data_out  <= w_shift_q;
                r_comma_det <= w_match;
                r_idle      <= w_active_nxt & ~w_match;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign comma_det  = r_comma_det;
    assign active     = r_active;
    assign idle_out   = r_idle;
    assign sync_lost  = r_sync_lost;

`ifdef SP_ERR_CNT_EN
    logic             w_off_match;
    logic [ERR_W-1:0] r_err_count;

    assign w_off_match = w_match && !w_boundary &&
                         ((r_state == ST_ALIGN) || (r_state == ST_LOCKED));

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            r_err_count <= '0;
        end else if (w_off_match && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_serial_paralelo_phy_rx_param.sv
// Purpose : self-checking bench for serial_paralelo_phy_rx_param against a symbol-grid reference model.
// Latency : checks every cycle on the falling edge, one cycle after the model's predicted edge.
// Backpr. : n/a -- the bench drives one bit per cycle.
module tb_serial_paralelo_phy_rx_param;

    localparam int         W       = 8;
    localparam logic [7:0] COMMA_V = 8'hBC;
    localparam int         LOCK_N  = 4;
    localparam int         LOSS_N  = 2;
`ifdef SP_ERR_CNT_EN
    localparam int         ERR_W   = 8;
`endif

    logic         clk_32f = 1'b0;
    logic         reset_L;
    logic         data_in;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         comma_det;
    logic         active;
    logic         idle_out;
    logic         sync_lost;
`ifdef SP_ERR_CNT_EN
    logic [ERR_W-1:0] err_count;
`endif

    always #5 clk_32f = ~clk_32f;

    serial_paralelo_phy_rx_param #(
        .WIDTH      (W),
        .COMMA      (COMMA_V),
        .LOCK_COUNT (LOCK_N),
        .LOSS_COUNT (LOSS_N)
`ifdef SP_ERR_CNT_EN
       ,.ERR_W      (ERR_W)
`endif
    ) dut (
        .clk_32f    (clk_32f),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .comma_det  (comma_det),
        .active     (active),
        .idle_out   (idle_out),
        .sync_lost  (sync_lost)
`ifdef SP_ERR_CNT_EN
       ,.err_count  (err_count)
`endif
    );

    int n_vec  = 0;
    int n_err  = 0;
    int n_lost = 0;

    // Reference model: the receive grid is an anchor edge number; an edge is on
    // the grid when it is a whole number of symbols after the anchor.
    logic [W-1:0] m_win;
    int           m_mode;    // 0 searching, 1 acquiring, 2 locked
    int           m_edge;
    int           m_anchor;
    int           m_good;
    int           m_bad;
    int           m_err;
    logic [W-1:0] e_data;
    logic         e_valid;
    logic         e_comma;
    logic         e_idle;
    logic         e_lost;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_win    = '0;
        m_mode   = 0;
        m_edge   = 0;
        m_anchor = 0;
        m_good   = 0;
        m_bad    = 0;
        m_err    = 0;
        e_data   = '0;
        e_valid  = 1'b0;
        e_comma  = 1'b0;
        e_idle   = 1'b0;
        e_lost   = 1'b0;
    endtask

    // Predict the effect of the coming rising edge, which also shifts in b.
    task automatic model_edge(input logic b);
        bit is_comma;
        bit on_grid;
        bit cap;
        is_comma = (m_win == COMMA_V);
        m_edge++;
        on_grid  = ((m_edge - m_anchor) % W) == 0;
        cap      = 1'b0;
        e_lost   = 1'b0;
        if (m_mode == 0) begin
            if (is_comma) begin
                cap      = 1'b1;
                m_anchor = m_edge;
                m_good   = 1;
                m_mode   = (LOCK_N == 1) ? 2 : 1;
            end
        end else if (m_mode == 1) begin
            if (on_grid) begin
                cap = 1'b1;
                if (is_comma) begin
                    m_good++;
                    if (m_good == LOCK_N) m_mode = 2;
                end
            end else if (is_comma) begin
                cap      = 1'b1;
                m_anchor = m_edge;
                m_good   = 1;
                m_err++;
            end
        end else begin
            if (on_grid) begin
                cap = 1'b1;
                if (is_comma) m_bad = 0;
            end else if (is_comma) begin
                m_err++;
                m_bad++;
                if (m_bad == LOSS_N) begin
                    m_mode = 0;
                    e_lost = 1'b1;
                    m_bad  = 0;
                    m_good = 0;
                end
            end
        end
`ifdef SP_ERR_CNT_EN
        if (m_err > (2**ERR_W) - 1) m_err = (2**ERR_W) - 1;
`endif
        e_valid = cap;
        if (cap) begin
            e_data  = m_win;
            e_comma = is_comma;
            e_idle  = (m_mode == 2) && !is_comma;
        end
        m_win = {m_win[W-2:0], b};
    endtask

    task automatic compare_outputs();
        chk("data_valid", 32'(data_valid), 32'(e_valid));
        chk("data_out",   32'(data_out),   32'(e_data));
        chk("comma_det",  32'(comma_det),  32'(e_comma));
        chk("active",     32'(active),     32'(m_mode == 2));
        chk("idle_out",   32'(idle_out),   32'(e_idle));
        chk("sync_lost",  32'(sync_lost),  32'(e_lost));
`ifdef SP_ERR_CNT_EN
        chk("err_count",  32'(err_count),  32'(m_err));
`endif
        if (sync_lost) n_lost++;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        compare_outputs();
        data_in = b;
        if (reset_L) model_edge(b);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    // Called at a falling edge right after send_bit: the bit just driven is
    // shifted in by the first edge out of reset.
    task automatic release_reset();
        reset_L = 1'b1;
        model_edge(data_in);
    endtask

    task automatic async_reset_check();
        @(posedge clk_32f);
        #2;
        reset_L = 1'b0;
        model_reset();
        #1;
        chk("arst_valid",  32'(data_valid), 32'd0);
        chk("arst_data",   32'(data_out),   32'd0);
        chk("arst_active", 32'(active),     32'd0);
        compare_outputs();
    endtask

    // Data symbols with bits 7 and 3 clear never contain a comma across any
    // symbol boundary, so scenario outcomes stay deterministic.
    function automatic logic [7:0] rnd_data();
        return 8'($urandom) & 8'h77;
    endfunction

    initial begin
        reset_L = 1'b0;
        data_in = 1'b0;
        model_reset();

        // Reset held with a toggling line: everything stays 0.
        for (int i = 0; i < 10; i++) send_bit(1'($urandom));
        chk("rst_valid",  32'(data_valid), 32'd0);
        chk("rst_active", 32'(active),     32'd0);
        send_bit(1'b0);
        release_reset();
        send_bits(32'd0, 2);

        // Four aligned commas acquire lock.
        repeat (4) send_bits(32'(COMMA_V), 8);

        // Non-comma symbol while locked is reported as idle traffic.
        send_bits(32'h55, 8);
        send_bits(32'd0, 2);
        chk("s3_data",   32'(data_out),  32'h55);
        chk("s3_comma",  32'(comma_det), 32'd0);
        chk("s3_idle",   32'(idle_out),  32'd1);
        chk("s3_active", 32'(active),    32'd1);
        send_bits(32'h11, 6);
        repeat (6) send_bits(32'(rnd_data()), 8);

        // One-bit slip: two misaligned commas drop lock, four more re-acquire.
        send_bit(1'b0);
        repeat (2) send_bits(32'(COMMA_V), 8);
        repeat (4) send_bits(32'(COMMA_V), 8);
        repeat (2) send_bits(32'(rnd_data()), 8);
        chk("s4_lost_pulses", 32'(n_lost), 32'd1);
        chk("s4_relock",      32'(active), 32'd1);
`ifdef SP_ERR_CNT_EN
        chk("s4_err_count",   32'(err_count), 32'd2);
`endif

        // Asynchronous reset mid-symbol while locked.
        send_bits(32'd5, 3);
        async_reset_check();
`ifdef SP_ERR_CNT_EN
        chk("arst_err", 32'(err_count), 32'd0);
`endif
        repeat (3) send_bit(1'($urandom));
        send_bit(1'b0);
        release_reset();

        // Acquisition restarts when a comma lands 3 bits off the grid.
        repeat (2) send_bits(32'(COMMA_V), 8);
        send_bits(32'd0, 3);
        repeat (3) send_bits(32'(COMMA_V), 8);
        send_bits(32'(rnd_data()), 8);
        chk("s5_not_yet", 32'(active), 32'd0);
        send_bits(32'(COMMA_V), 8);
        send_bits(32'(rnd_data()), 8);
        chk("s5_locked",  32'(active), 32'd1);
`ifdef SP_ERR_CNT_EN
        chk("s5_err_count", 32'(err_count), 32'd1);
`endif

        // Random mix of commas, data, slips and unconstrained noise.
        for (int k = 0; k < 80; k++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 4)       send_bits(32'(COMMA_V), 8);
            else if (sel < 8)  send_bits(32'(rnd_data()), 8);
            else if (sel == 8) send_bits(32'd0, $urandom_range(1, 7));
            else               send_bits($urandom, 8);
        end
        send_bits(32'd0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
